// File: rtl/pipe_stall_arbiter.sv
// pipe_stall_arbiter
// Stall and memory-arbitration controller for the pipelined core. Blocking
// memory requests are granted one at a time to the shared memory port. Every
// pipeline register stays frozen until all requests of the current pipeline
// cycle are served. The controller also inserts the load/store bubble and
// keeps a saturating count of stall cycles.
// Optional feature: define STALL_ARB_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest index wins.

module pipe_stall_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic                  mem_complete_i,
  input  logic                  ex_mem_access_i,
  output logic [NUM_REQ-1:0]    mem_grant_o,
  output logic [NUM_STAGES-1:0] stage_write_o,
  output logic                  insert_bubble_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] served_q, served_d;
  logic [NUM_REQ-1:0] memGrant_q, memGrant_d;
  logic [CNT_W-1:0]   stallCycles_q, stallCycles_d;
  logic [NUM_REQ-1:0] pending;
  logic               anyPending;
  logic [PTR_W-1:0]   selIdx;
  logic [NUM_REQ-1:0] selOneHot;

`ifdef STALL_ARB_RR_EN
  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
`endif

  // A channel is pending while it requests and has not been served in this
  // pipeline cycle.
  assign pending    = req_i & ~served_q;
  assign anyPending = |pending;

`ifdef STALL_ARB_RR_EN
  // Round-robin pick: scan from rrPtr downward so that the smallest offset wins.
  always_comb begin
    int idx;
    idx    = 0;
    selIdx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rrPtr_q) + i) % NUM_REQ;
      if (pending[idx]) selIdx = PTR_W'(idx);
    end
  end
`else
  // Fixed-priority pick: the lowest pending index wins.
  always_comb begin
    selIdx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) selIdx = PTR_W'(i);
    end
  end
`endif

  assign selOneHot = NUM_REQ'(1) << selIdx;

  // Grant FSM next state. A completion marks the granted channel as served.
  // Any cycle with nothing pending means the pipeline advanced, so the
  // served mask starts over.
  always_comb begin
    state_d    = state_q;
    memGrant_d = memGrant_q;
    served_d   = served_q;
`ifdef STALL_ARB_RR_EN
    rrPtr_d    = rrPtr_q;
`endif
    case (state_q)
      IDLE: begin
        if (anyPending) begin
          memGrant_d = selOneHot;
          state_d    = BUSY;
`ifdef STALL_ARB_RR_EN
          rrPtr_d    = (selIdx == PTR_W'(NUM_REQ - 1)) ? '0 : selIdx + PTR_W'(1);
`endif
        end
      end
      BUSY: begin
        if (mem_complete_i) begin
          served_d   = served_q | memGrant_q;
          memGrant_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!anyPending) served_d = '0;
  end

  // Stage enables: a pending request freezes everything. Otherwise a memory
  // op in ID/EX holds PC and IF/ID and bubbles ID/EX. While reset is high,
  // everything is held.
  always_comb begin
    stage_write_o   = '0;
    insert_bubble_o = 1'b0;
    if (!reset_i && !anyPending) begin
      stage_write_o = {NUM_STAGES{1'b1}};
      if (ex_mem_access_i) begin
        stage_write_o[1:0] = 2'b00;
        insert_bubble_o    = 1'b1;
      end
    end
  end

  // The stall counter counts fully frozen cycles and sticks at its maximum.
  always_comb begin
    stallCycles_d = stallCycles_q;
    if ((stage_write_o == '0) && (stallCycles_q != {CNT_W{1'b1}}))
      stallCycles_d = stallCycles_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      served_q      <= '0;
      memGrant_q    <= '0;
      stallCycles_q <= '0;
`ifdef STALL_ARB_RR_EN
      rrPtr_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      served_q      <= served_d;
      memGrant_q    <= memGrant_d;
      stallCycles_q <= stallCycles_d;
`ifdef STALL_ARB_RR_EN
      rrPtr_q       <= rrPtr_d;
`endif
    end
  end

  assign mem_grant_o    = memGrant_q;
  assign busy_o         = (state_q == BUSY) && !reset_i;
  assign stall_cycles_o = stallCycles_q;

endmodule

// File: tb/tb_pipe_stall_arbiter.sv
// Testbench for pipe_stall_arbiter with NUM_REQ=3, NUM_STAGES=5, CNT_W=4.
// Expected grants come from a small arbitration model. They are queued when
// requests are driven and popped when the DUT raises a grant.
// Defining STALL_ARB_RR_EN switches the model to round-robin.

module tb_pipe_stall_arbiter;

  logic       clock;
  logic       reset;
  logic [2:0] req;
  logic       memComplete;
  logic       exMemAccess;
  logic [2:0] memGrant;
  logic [4:0] stageWrite;
  logic       insertBubble;
  logic       busy;
  logic [3:0] stallCycles;

  int passCount  = 0;
  int checkCount = 0;

  logic [2:0] expGrantQ[$];
  int         modelPtr = 0;

  pipe_stall_arbiter #(
    .NUM_REQ   (3),
    .NUM_STAGES(5),
    .CNT_W     (4)
  ) dut (
    .clk_i          (clock),
    .reset_i        (reset),
    .req_i          (req),
    .mem_complete_i (memComplete),
    .ex_mem_access_i(exMemAccess),
    .mem_grant_o    (memGrant),
    .stage_write_o  (stageWrite),
    .insert_bubble_o(insertBubble),
    .busy_o         (busy),
    .stall_cycles_o (stallCycles)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so that the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, passed %0d of %0d", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference arbitration: the lowest index wins, or a round-robin scan from ptr.
  function automatic logic [2:0] modelPick(input logic [2:0] p, input int ptr);
`ifdef STALL_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (ptr + k) % 3;
      if (p[j]) return 3'b001 << j;
    end
`else
    if (ptr < 0) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (p[k]) return 3'b001 << k;
    end
`endif
    return 3'b000;
  endfunction

  function automatic int modelNext(input logic [2:0] g);
    if (g[0]) return 1;
    if (g[1]) return 2;
    return 0;
  endfunction

  // Predicts the whole grant sequence for one pipeline cycle and queues it.
  task automatic applyStimulus(input logic [2:0] r);
    logic [2:0] pend;
    logic [2:0] g;
    req  = r;
    pend = r;
    while (pend != 3'b000) begin
      g = modelPick(pend, modelPtr);
      expGrantQ.push_back(g);
      modelPtr = modelNext(g);
      pend = pend & ~g;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    req         = 3'b000;
    memComplete = 1'b0;
    exMemAccess = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    modelPtr = 0;
    expGrantQ.delete();
  endtask

  task automatic test_reset();
    logic [2:0] dummy;
    reset       = 1'b1;
    req         = 3'b000;
    memComplete = 1'b0;
    exMemAccess = 1'b1;
    tick();
    #1;
    checkCount++; if (stageWrite !== 5'b00000) $display("[TB] FAIL rst_stage_write: got %b expected %b", stageWrite, 5'b00000); else passCount++;
    checkCount++; if (insertBubble !== 1'b0) $display("[TB] FAIL rst_bubble: got %b expected %b", insertBubble, 1'b0); else passCount++;
    exMemAccess = 1'b0;
    req = 3'b001;
    tick();
    #1;
    checkCount++; if (memGrant !== 3'b000) $display("[TB] FAIL rst_grant: got %b expected %b", memGrant, 3'b000); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected %b", busy, 1'b0); else passCount++;
    checkCount++; if (stallCycles !== 4'd0) $display("[TB] FAIL rst_stall: got %0d expected %0d", stallCycles, 0); else passCount++;
    req = 3'b000;
    tick();
    reset = 1'b0;
    #1;
    checkCount++; if (stageWrite !== 5'b11111) $display("[TB] FAIL rst_release_stage_write: got %b expected %b", stageWrite, 5'b11111); else passCount++;
    dummy = 3'b000;
    tick();
  endtask

  task automatic test_single_request();
    logic [2:0] exp;
    doReset();
    applyStimulus(3'b001);
    #1;
    checkCount++; if (stageWrite !== 5'b00000) $display("[TB] FAIL sr_freeze: got %b expected %b", stageWrite, 5'b00000); else passCount++;
    tick();
    #1;
    exp = (expGrantQ.size() > 0) ? expGrantQ.pop_front() : 3'bxxx;
    checkCount++; if (memGrant !== exp) $display("[TB] FAIL sr_grant: got %b expected %b", memGrant, exp); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL sr_busy: got %b expected %b", busy, 1'b1); else passCount++;
    tick();
    tick();
    memComplete = 1'b1;
    #1;
    checkCount++; if (memGrant !== exp) $display("[TB] FAIL sr_grant_hold: got %b expected %b", memGrant, exp); else passCount++;
    tick();
    memComplete = 1'b0;
    #1;
    checkCount++; if (memGrant !== 3'b000) $display("[TB] FAIL sr_release: got %b expected %b", memGrant, 3'b000); else passCount++;
    checkCount++; if (stageWrite !== 5'b11111) $display("[TB] FAIL sr_advance: got %b expected %b", stageWrite, 5'b11111); else passCount++;
    checkCount++; if (stallCycles !== 4'd4) $display("[TB] FAIL sr_stall_count: got %0d expected %0d", stallCycles, 4); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL sr_idle: got %b expected %b", busy, 1'b0); else passCount++;
    req = 3'b000;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] prevGrant;
    logic [2:0] exp;
    int grantStart;
    int nGrants;
    int advCycle;
    int expCycle;
    doReset();
    for (int r = 0; r < 2; r++) begin
      applyStimulus(3'b011);
      prevGrant  = 3'b000;
      grantStart = -100;
      nGrants    = 0;
      advCycle   = -1;
      for (int c = 0; c < 20 && advCycle < 0; c++) begin
        #1;
        if (memGrant != 3'b000 && prevGrant == 3'b000) begin
          checkCount++;
          if (expGrantQ.size() == 0) begin
            $display("[TB] FAIL b2b_unexpected_grant: round %0d got %b expected none", r, memGrant);
          end else begin
            exp = expGrantQ.pop_front();
            if (memGrant !== exp) $display("[TB] FAIL b2b_grant: round %0d got %b expected %b", r, memGrant, exp); else passCount++;
          end
          expCycle = (nGrants == 0) ? 1 : 4;
          checkCount++; if (c != expCycle) $display("[TB] FAIL b2b_grant_cycle: round %0d got %0d expected %0d", r, c, expCycle); else passCount++;
          grantStart = c;
          nGrants++;
        end
        if (stageWrite === 5'b11111) advCycle = c;
        memComplete = (memGrant != 3'b000) && (c == grantStart + 1);
        prevGrant = memGrant;
        tick();
      end
      checkCount++; if (advCycle != 6) $display("[TB] FAIL b2b_advance_cycle: round %0d got %0d expected %0d", r, advCycle, 6); else passCount++;
      checkCount++; if (expGrantQ.size() != 0) $display("[TB] FAIL b2b_missing_grants: round %0d got %0d left expected 0", r, expGrantQ.size()); else passCount++;
      expGrantQ.delete();
    end
    req = 3'b000;
    memComplete = 1'b0;
    tick();
  endtask

  task automatic test_bubble();
    logic [2:0] exp;
    doReset();
    exMemAccess = 1'b1;
    #1;
    checkCount++; if (stageWrite !== 5'b11100) $display("[TB] FAIL bub_stage_write: got %b expected %b", stageWrite, 5'b11100); else passCount++;
    checkCount++; if (insertBubble !== 1'b1) $display("[TB] FAIL bub_insert: got %b expected %b", insertBubble, 1'b1); else passCount++;
    applyStimulus(3'b100);
    #1;
    checkCount++; if (stageWrite !== 5'b00000) $display("[TB] FAIL bub_freeze_wins: got %b expected %b", stageWrite, 5'b00000); else passCount++;
    checkCount++; if (insertBubble !== 1'b0) $display("[TB] FAIL bub_no_bubble_when_pending: got %b expected %b", insertBubble, 1'b0); else passCount++;
    tick();
    #1;
    exp = (expGrantQ.size() > 0) ? expGrantQ.pop_front() : 3'bxxx;
    checkCount++; if (memGrant !== exp) $display("[TB] FAIL bub_grant: got %b expected %b", memGrant, exp); else passCount++;
    memComplete = 1'b1;
    tick();
    memComplete = 1'b0;
    #1;
    checkCount++; if (stageWrite !== 5'b11100) $display("[TB] FAIL bub_after_serve: got %b expected %b", stageWrite, 5'b11100); else passCount++;
    checkCount++; if (insertBubble !== 1'b1) $display("[TB] FAIL bub_after_serve_insert: got %b expected %b", insertBubble, 1'b1); else passCount++;
    req = 3'b000;
    exMemAccess = 1'b0;
    tick();
    #1;
    checkCount++; if (stageWrite !== 5'b11111 || insertBubble !== 1'b0) $display("[TB] FAIL bub_clear: got %b/%b expected %b/%b", stageWrite, insertBubble, 5'b11111, 1'b0); else passCount++;
  endtask

  task automatic test_reset_mid_access();
    logic [2:0] exp;
    doReset();
    applyStimulus(3'b010);
    tick();
    #1;
    exp = (expGrantQ.size() > 0) ? expGrantQ.pop_front() : 3'bxxx;
    checkCount++; if (memGrant !== exp) $display("[TB] FAIL rma_grant: got %b expected %b", memGrant, exp); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL rma_busy: got %b expected %b", busy, 1'b1); else passCount++;
    reset = 1'b1;
    req   = 3'b000;
    #1;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rma_busy_in_reset: got %b expected %b", busy, 1'b0); else passCount++;
    checkCount++; if (stageWrite !== 5'b00000) $display("[TB] FAIL rma_stage_in_reset: got %b expected %b", stageWrite, 5'b00000); else passCount++;
    tick();
    reset = 1'b0;
    modelPtr = 0;
    memComplete = 1'b1;
    #1;
    checkCount++; if (memGrant !== 3'b000) $display("[TB] FAIL rma_grant_cleared: got %b expected %b", memGrant, 3'b000); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rma_idle: got %b expected %b", busy, 1'b0); else passCount++;
    tick();
    memComplete = 1'b0;
    #1;
    checkCount++; if (memGrant !== 3'b000 || busy !== 1'b0) $display("[TB] FAIL rma_complete_ignored: got %b/%b expected %b/%b", memGrant, busy, 3'b000, 1'b0); else passCount++;
    checkCount++; if (stageWrite !== 5'b11111) $display("[TB] FAIL rma_stage_write: got %b expected %b", stageWrite, 5'b11111); else passCount++;
    checkCount++; if (stallCycles !== 4'd0) $display("[TB] FAIL rma_stall: got %0d expected %0d", stallCycles, 0); else passCount++;
    applyStimulus(3'b010);
    tick();
    #1;
    exp = (expGrantQ.size() > 0) ? expGrantQ.pop_front() : 3'bxxx;
    checkCount++; if (memGrant !== exp) $display("[TB] FAIL rma_regrant: got %b expected %b", memGrant, exp); else passCount++;
    memComplete = 1'b1;
    tick();
    memComplete = 1'b0;
    req = 3'b000;
    tick();
  endtask

  task automatic test_saturation();
    logic [2:0] exp;
    doReset();
    applyStimulus(3'b001);
    for (int c = 0; c <= 20; c++) begin
      #1;
      if (c == 1) begin
        exp = (expGrantQ.size() > 0) ? expGrantQ.pop_front() : 3'bxxx;
        checkCount++; if (memGrant !== exp) $display("[TB] FAIL sat_grant: got %b expected %b", memGrant, exp); else passCount++;
      end
      if (c == 14) begin
        checkCount++; if (stallCycles !== 4'd14) $display("[TB] FAIL sat_count_14: got %0d expected %0d", stallCycles, 14); else passCount++;
      end
      if (c == 15) begin
        checkCount++; if (stallCycles !== 4'd15) $display("[TB] FAIL sat_count_15: got %0d expected %0d", stallCycles, 15); else passCount++;
      end
      if (c == 20) begin
        checkCount++; if (stallCycles !== 4'd15) $display("[TB] FAIL sat_hold: got %0d expected %0d", stallCycles, 15); else passCount++;
      end
      tick();
    end
    doReset();
  endtask

  initial begin
    reset       = 1'b1;
    req         = 3'b000;
    memComplete = 1'b0;
    exMemAccess = 1'b0;
    test_reset();
    test_single_request();
    test_back_to_back();
    test_bubble();
    test_reset_mid_access();
    test_saturation();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
